// File: rtl/fp32_accumulate.sv
// fp32_accumulate: sequential FP32 running-sum adder (flush-to-zero, round-to-nearest-even).
// One term in flight at a time; a five-state FSM walks it through align, add, normalise, round.
module fp32_accumulate #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] QNAN       = 32'h7FC0_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] product_i,
    input  logic                  clear_i,
    input  logic                  last_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t             state;
    logic               nan_sticky;

    // Per-term datapath registers, reused from stage to stage.
    logic [31:0]        op_a, op_b;
    logic               term_nan, term_last;
    logic [26:0]        big_m, small_m;
    logic [27:0]        sum_m;
    logic [26:0]        norm_m;
    logic signed [9:0]  exp_w;
    logic               res_sign, eff_sub, zero_q;

    // ALIGN: unpack with flush-to-zero, order by magnitude, shift the smaller into {mant,G,R,S}.
    logic [7:0]  ea, eb, big_e, small_e, shift;
    logic [23:0] ma, mb, big_mt, small_mt;
    logic [26:0] small_ext, shifted, aligned;
    logic        a_ge, sticky;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ea       = op_a[30:23];
        eb       = op_b[30:23];
        ma       = (ea == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
        mb       = (eb == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
        a_ge     = {ea, ma} >= {eb, mb};
        big_e    = a_ge ? ea : eb;
        small_e  = a_ge ? eb : ea;
        big_mt   = a_ge ? ma : mb;
        small_mt = a_ge ? mb : ma;
        shift    = big_e - small_e;
        small_ext = {small_mt, 3'b000};
        shifted  = 27'd0;
        sticky   = |small_mt;
        if (shift < 8'd27) begin
            shifted = small_ext >> shift;
            sticky  = |(small_ext & ((27'd1 << shift) - 27'd1));
        end
        aligned = {shifted[26:1], shifted[0] | sticky};
    end

    // NORM: carry renormalises right (sticky kept), otherwise shift out leading zeros.
    logic [4:0]        lzc;
    logic [26:0]       n_m;
    logic signed [9:0] n_e;
    logic              n_zero;

    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_m[i]) lzc = 5'(26 - i);
        end
        n_zero = (sum_m == 28'd0);
        if (sum_m[27]) begin
            n_m = {sum_m[27:2], sum_m[1] | sum_m[0]};
            n_e = exp_w + 10'sd1;
        end else begin
            n_m = sum_m[26:0] << lzc;
            n_e = exp_w - $signed({5'd0, lzc});
        end
        if (n_e <= 10'sd0) n_zero = 1'b1;
    end

    // ROUND: nearest-even on G,R,S; a mantissa carry bumps the exponent; saturate to Inf.
    logic              rnd_up;
    logic [24:0]       mant25;
    logic [22:0]       frac;
    logic signed [9:0] r_e;
    logic [31:0]       result;

    always_comb begin
        rnd_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        mant25 = {1'b0, norm_m[26:3]} + {24'd0, rnd_up};
        frac   = mant25[24] ? mant25[23:1] : mant25[22:0];
        r_e    = mant25[24] ? exp_w + 10'sd1 : exp_w;
        if (zero_q)
            result = 32'd0;
        else if (r_e >= 10'sd255)
            result = {res_sign, 8'hFF, 23'd0};
        else
            result = {res_sign, r_e[7:0], frac};
    end

    // Control and architectural state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            sum_o      <= '0;
            done_o     <= 1'b0;
            nan_sticky <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        state   <= ALIGN;
                        ready_o <= 1'b0;
                    end else if (clear_i) begin
                        sum_o      <= '0;
                        nan_sticky <= 1'b0;
                    end
                end
                ALIGN: state <= ADD;
                ADD:   state <= NORM;
                NORM:  state <= ROUND;
                ROUND: begin
                    sum_o      <= term_nan ? QNAN : result;
                    nan_sticky <= term_nan;
                    done_o     <= term_last;
                    ready_o    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never consumes them before loading them.
    always_ff @(posedge clk_i) begin
        unique case (state)
            IDLE: begin
                if (valid_i) begin
                    op_a      <= clear_i ? 32'd0 : sum_o;
                    op_b      <= product_i;
                    term_nan  <= (&product_i[30:23])
                               | (!clear_i & (nan_sticky | (&sum_o[30:23])));
                    term_last <= last_i;
                end
            end
            ALIGN: begin
                big_m    <= {big_mt, 3'b000};
                small_m  <= aligned;
                exp_w    <= $signed({2'b00, big_e});
                res_sign <= a_ge ? op_a[31] : op_b[31];
                eff_sub  <= op_a[31] ^ op_b[31];
            end
            ADD: begin
                sum_m <= eff_sub ? {1'b0, big_m} - {1'b0, small_m}
                                 : {1'b0, big_m} + {1'b0, small_m};
            end
            NORM: begin
                norm_m <= n_m;
                exp_w  <= n_e;
                zero_q <= n_zero;
            end
            ROUND: ;
            default: ;
        endcase
    end

endmodule
